// File: rtl/uart_rx_cfg.sv
// -----------------------------------------------------------------------------
// uart_rx_cfg
//   Parametrised UART receiver. The serial line is synchronised through two
//   flops. Each bit is sampled once, near its centre, using a tick counter
//   driven by the oversampling sample_tick from the shared baud generator.
//   Received words go out through a valid/ready handshake. Parity, framing and
//   overrun errors are reported alongside the word.
//
// Parameters
//   DATA_BITS   data bits per frame (5..9), LSB first
//   OVERSAMPLE  sample_tick pulses per bit period (even, >= 4)
//   PARITY_EN   1 = a parity bit follows the data
//   PARITY_ODD  1 = odd parity, 0 = even
//   STOP_BITS   stop bits checked (1 or 2)
//
// Ports
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   sample_tick  one-clock pulse at OVERSAMPLE x baud
//   rx_in        asynchronous serial input, idle high
//   data_out     received word, stable while data_valid is high
//   data_valid   word available, held until accepted
//   data_ready   consumer accepts the word on a clock edge with data_valid high
//   parity_err   parity mismatch for the word in data_out
//   frame_err    a stop bit was sampled low for the word in data_out
//   overrun_err  one or more later frames were dropped while data_out was pending
//   busy         frame reception in progress
// -----------------------------------------------------------------------------
module uart_rx_cfg #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 sample_tick,
    input  logic                 rx_in,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_valid,
    input  logic                 data_ready,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun_err,
    output logic                 busy
);

    localparam int CNT_W = $clog2(OVERSAMPLE);
    localparam int BIT_W = $clog2(DATA_BITS + 1);

    localparam logic [CNT_W-1:0] HALF_M1   = CNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_M1   = CNT_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0] LAST_DATA = BIT_W'(DATA_BITS - 1);
    localparam logic [BIT_W-1:0] LAST_STOP = BIT_W'(STOP_BITS - 1);
    localparam logic             PAR_ODD   = (PARITY_ODD != 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t               state_q;
    logic                 sync1_q;
    logic                 sync2_q;
    logic                 rx_prev_q;
    logic [CNT_W-1:0]     tick_cnt_q;
    logic [BIT_W-1:0]     bit_cnt_q;
    logic [DATA_BITS-1:0] shift_q;
    logic                 par_err_acc_q;
    logic                 frm_err_acc_q;
    logic                 busy_q;

    logic [DATA_BITS-1:0] data_q;
    logic                 valid_q;
    logic                 perr_q;
    logic                 ferr_q;
    logic                 ovr_q;

    logic rxs;
    logic deliver_d;
    logic accept_d;
    logic par_bad_d;
    logic frm_bad_d;

    assign rxs = sync2_q;

    // The final stop-bit sample completes the frame on this tick.
    assign deliver_d = sample_tick && (state_q == S_STOP) &&
                       (tick_cnt_q == FULL_M1) && (bit_cnt_q == LAST_STOP);
    assign accept_d  = valid_q && data_ready;

    // Parity over the shifted-in data plus the bit being sampled now.
    assign par_bad_d = ((^shift_q) ^ rxs) != PAR_ODD;

    // Frame error including the stop bit being sampled on this tick.
    assign frm_bad_d = frm_err_acc_q | ~rxs;

    // Two-flop synchroniser; resets to the idle (high) line level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= rx_in;
            sync2_q <= sync1_q;
        end
    end

    // Receive FSM; all progress is gated by sample_tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            rx_prev_q     <= 1'b1;
            tick_cnt_q    <= '0;
            bit_cnt_q     <= '0;
            shift_q       <= '0;
            par_err_acc_q <= 1'b0;
            frm_err_acc_q <= 1'b0;
            busy_q        <= 1'b0;
        end else if (sample_tick) begin
            // Previous-tick sample; a start needs a true 1->0 edge, so a line
            // stuck low after a break cannot re-trigger reception.
            rx_prev_q <= rxs;
            case (state_q)
                S_IDLE: begin
                    if (rx_prev_q && !rxs) begin
                        state_q    <= S_START;
                        tick_cnt_q <= '0;
                        busy_q     <= 1'b1;
                    end
                end
                S_START: begin
                    if (tick_cnt_q == HALF_M1) begin
                        tick_cnt_q <= '0;
                        if (!rxs) begin
                            state_q       <= S_DATA;
                            bit_cnt_q     <= '0;
                            par_err_acc_q <= 1'b0;
                            frm_err_acc_q <= 1'b0;
                        end else begin
                            // Line went high again before mid start bit: glitch.
                            state_q <= S_IDLE;
                            busy_q  <= 1'b0;
                        end
                    end else begin
                        tick_cnt_q <= tick_cnt_q + CNT_W'(1);
                    end
                end
                S_DATA: begin
                    if (tick_cnt_q == FULL_M1) begin
                        tick_cnt_q <= '0;
                        // LSB arrives first; shifting in at the MSB leaves it in bit 0.
                        shift_q    <= {rxs, shift_q[DATA_BITS-1:1]};
                        if (bit_cnt_q == LAST_DATA) begin
                            bit_cnt_q <= '0;
                            state_q   <= (PARITY_EN != 0) ? S_PARITY : S_STOP;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + BIT_W'(1);
                        end
                    end else begin
                        tick_cnt_q <= tick_cnt_q + CNT_W'(1);
                    end
                end
                S_PARITY: begin
                    if (tick_cnt_q == FULL_M1) begin
                        tick_cnt_q    <= '0;
                        par_err_acc_q <= par_bad_d;
                        state_q       <= S_STOP;
                    end else begin
                        tick_cnt_q <= tick_cnt_q + CNT_W'(1);
                    end
                end
                S_STOP: begin
                    if (tick_cnt_q == FULL_M1) begin
                        tick_cnt_q <= '0;
                        if (bit_cnt_q == LAST_STOP) begin
                            state_q   <= S_IDLE;
                            busy_q    <= 1'b0;
                            bit_cnt_q <= '0;
                        end else begin
                            frm_err_acc_q <= frm_bad_d;
                            bit_cnt_q     <= bit_cnt_q + BIT_W'(1);
                        end
                    end else begin
                        tick_cnt_q <= tick_cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // Output word and handshake. Delivery has priority over a plain accept;
    // a delivery that coincides with an accept replaces the word cleanly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else if (deliver_d) begin
            if (valid_q && !data_ready) begin
                // Pending word not taken: drop the new one and flag it.
                ovr_q <= 1'b1;
            end else begin
                data_q  <= shift_q;
                perr_q  <= par_err_acc_q;
                ferr_q  <= frm_bad_d;
                valid_q <= 1'b1;
                ovr_q   <= 1'b0;
            end
        end else if (accept_d) begin
            valid_q <= 1'b0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end
    end

    assign data_out    = data_q;
    assign data_valid  = valid_q;
    assign parity_err  = perr_q;
    assign frame_err   = ferr_q;
    assign overrun_err = ovr_q;
    assign busy        = busy_q;

endmodule
